// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative multiply/divide sequencer that owns the HI/LO pair.
// MULT/MULTU run a radix-2 shift-add loop and DIV/DIVU run a restoring divide
// loop, one iteration per cycle, on operand magnitudes with the sign applied
// at the end. STALL holds later HI/LO users in E while the unit is busy.
// Optional feature macro: MULDIV_FAST_MUL_EN (single-cycle multiply path).
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic [1:0]       op_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    input  logic             mthi_i,
    input  logic             mtlo_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             rd_hilo_i,
    output logic             busy_o,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_e;

    state_e               state_q;
    logic [CW-1:0]        count_q;
    logic                 isDiv_q;
    logic                 negQuot_q;
    logic                 negRem_q;
    logic                 done_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [WIDTH-1:0]     operand_q;
    logic [WIDTH-1:0]     hi_q;
    logic [WIDTH-1:0]     lo_q;

    logic                 signA;
    logic                 signB;
    logic [WIDTH-1:0]     magA;
    logic [WIDTH-1:0]     magB;
    logic [WIDTH:0]       mulSum;
    logic [2*WIDTH-1:0]   mulNext;
    logic [WIDTH:0]       remShift;
    logic [WIDTH:0]       remDiff;
    logic [2*WIDTH-1:0]   divNext;
    logic [WIDTH-1:0]     fixHi;
    logic [WIDTH-1:0]     fixLo;

    // Operand signs and magnitudes; the unsigned ops (op bit 0 set) never negate.
    always_comb begin
        signA = ~op_i[0] & src_a_i[WIDTH-1];
        signB = ~op_i[0] & src_b_i[WIDTH-1];
        magA  = signA ? -src_a_i : src_a_i;
        magB  = signB ? -src_b_i : src_b_i;
    end

    // One loop iteration. Multiply keeps {partial, multiplier} in acc_q and
    // shifts right; divide keeps {remainder, dividend/quotient} and shifts left.
    always_comb begin
        mulSum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, operand_q} : '0);
        mulNext  = {mulSum, acc_q[WIDTH-1:1]};
        remShift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        remDiff  = remShift - {1'b0, operand_q};
        if (remDiff[WIDTH]) begin
            divNext = {remShift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
        end else begin
            divNext = {remDiff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        end
    end

    // Sign correction of the finished magnitude result before it lands in HI/LO.
    always_comb begin
        if (isDiv_q) begin
            fixHi = negRem_q  ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            fixLo = negQuot_q ? -acc_q[WIDTH-1:0]       : acc_q[WIDTH-1:0];
        end else begin
            {fixHi, fixLo} = negQuot_q ? -acc_q : acc_q;
        end
    end

    // Sequencer FSM with the datapath registers, HI/LO and the DONE pulse.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            count_q   <= '0;
            isDiv_q   <= 1'b0;
            negQuot_q <= 1'b0;
            negRem_q  <= 1'b0;
            done_q    <= 1'b0;
            acc_q     <= '0;
            operand_q <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_i) begin
                        isDiv_q   <= op_i[1];
                        negQuot_q <= signA ^ signB;
                        negRem_q  <= signA;
                        count_q   <= CW'(WIDTH - 1);
                        if (op_i[1] && (src_b_i == '0)) begin
                            // Divide by zero: HI takes the raw dividend, LO all ones.
                            acc_q     <= {src_a_i, {WIDTH{1'b1}}};
                            negQuot_q <= 1'b0;
                            negRem_q  <= 1'b0;
                            state_q   <= FIX;
                            done_q    <= 1'b1;
                        end else if (op_i[1]) begin
                            acc_q     <= {{WIDTH{1'b0}}, magA};
                            operand_q <= magB;
                            state_q   <= RUN;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc_q   <= (2*WIDTH)'(magA) * (2*WIDTH)'(magB);
                            state_q <= FIX;
                            done_q  <= 1'b1;
`else
                            acc_q     <= {{WIDTH{1'b0}}, magB};
                            operand_q <= magA;
                            state_q   <= RUN;
`endif
                        end
                    end else begin
                        if (mthi_i) begin
                            hi_q <= wdata_i;
                        end
                        if (mtlo_i) begin
                            lo_q <= wdata_i;
                        end
                    end
                end
                RUN: begin
                    acc_q <= isDiv_q ? divNext : mulNext;
                    if (count_q == '0) begin
                        state_q <= FIX;
                        done_q  <= 1'b1;
                    end else begin
                        count_q <= count_q - CW'(1);
                    end
                end
                FIX: begin
                    hi_q    <= fixHi;
                    lo_q    <= fixLo;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy_o  = (state_q != IDLE);
    assign stall_o = busy_o & (start_i | mthi_i | mtlo_i | rd_hilo_i);
    assign done_o  = done_q;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: self-checking bench for muldiv_seq. A behavioural model
// (plain 64-bit arithmetic plus a remaining-latency counter) predicts HI/LO,
// BUSY, DONE and STALL every cycle; directed operations pin literal results.
module tb_muldiv_seq;

`ifdef MULDIV_FAST_MUL_EN
   localparam bit FAST = 1'b1;
`else
   localparam bit FAST = 1'b0;
`endif
   localparam int LONG_LAT = 33;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  opSel;
   logic [31:0] srcA;
   logic [31:0] srcB;
   logic        mthi;
   logic        mtlo;
   logic [31:0] wdata;
   logic        rdHilo;
   logic        busy;
   logic        stall;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   int          remaining = 0;
   logic [31:0] mHi = '0;
   logic [31:0] mLo = '0;
   logic [31:0] pHi = '0;
   logic [31:0] pLo = '0;
   bit          modelValid = 1'b0;
   bit          doneSeen = 1'b0;

   muldiv_seq #(.WIDTH(32)) dut (
      .clk_i     (clk),
      .reset_i   (reset),
      .start_i   (start),
      .op_i      (opSel),
      .src_a_i   (srcA),
      .src_b_i   (srcB),
      .mthi_i    (mthi),
      .mtlo_i    (mtlo),
      .wdata_i   (wdata),
      .rd_hilo_i (rdHilo),
      .busy_o    (busy),
      .stall_o   (stall),
      .done_o    (done),
      .hi_o      (hi),
      .lo_o      (lo)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference result {HI,LO} straight from the arithmetic definitions.
   function automatic logic [63:0] refResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint sa;
      longint sb;
      longint q;
      longint r;
      logic [63:0] res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      res = '0;
      case (op)
         2'b00: res = 64'(sa * sb);
         2'b01: res = {32'b0, a} * {32'b0, b};
         2'b10: begin
            if (b == 0) begin
               res = {a, 32'hFFFF_FFFF};
            end else begin
               q = sa / sb;
               r = sa % sb;
               res = {r[31:0], q[31:0]};
            end
         end
         default: begin
            if (b == 0) res = {a, 32'hFFFF_FFFF};
            else        res = {a % b, a / b};
         end
      endcase
      return res;
   endfunction

   // Cycles the unit stays busy after accepting an operation.
   function automatic int refLatency(input logic [1:0] op, input logic [31:0] b);
      if (op[1] && b == 0) return 1;
      if (!op[1] && FAST)  return 1;
      return LONG_LAT;
   endfunction

   // Behavioural model advanced on every active edge.
   always @(posedge clk) begin
      if (reset) begin
         remaining  = 0;
         mHi        = '0;
         mLo        = '0;
         modelValid = 1'b1;
      end else if (remaining > 0) begin
         remaining = remaining - 1;
         if (remaining == 0) begin
            mHi = pHi;
            mLo = pLo;
         end
      end else if (start) begin
         {pHi, pLo} = refResult(opSel, srcA, srcB);
         remaining  = refLatency(opSel, srcB);
      end else begin
         if (mthi) mHi = wdata;
         if (mtlo) mLo = wdata;
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison of every output against the model, mid-cycle.
   always @(negedge clk) begin
      if (modelValid) begin
         if (done === 1'b1) doneSeen = 1'b1;
         checkOutput("busy", 64'(busy), 64'(remaining > 0));
         checkOutput("done", 64'(done), 64'(remaining == 1));
         checkOutput("stall", 64'(stall), 64'((remaining > 0) && (start || mthi || mtlo || rdHilo)));
         checkOutput("hi", 64'(hi), 64'(mHi));
         checkOutput("lo", 64'(lo), 64'(mLo));
      end
   end

   // Issues one operation, optionally holds MFHI/MFLO in E, and checks
   // timing and the final HI/LO against hand-computed values.
   task automatic applyStimulus(input string name, input logic [1:0] op, input logic [31:0] a,
                                input logic [31:0] b, input bit rd,
                                input logic [31:0] expHi, input logic [31:0] expLo);
      int k;
      int doneAt;
      int busyCnt;
      int stallCnt;
      int expLat;
      expLat = refLatency(op, b);
      @(posedge clk); #2;
      start = 1'b1; opSel = op; srcA = a; srcB = b;
      @(posedge clk); #2;
      start = 1'b0; rdHilo = rd;
      k = 1; doneAt = 0; busyCnt = 0; stallCnt = 0;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1) break;
         busyCnt++;
         if (done === 1'b1) doneAt = k;
         if (stall === 1'b1) stallCnt++;
         if (k >= 100) break;
         @(posedge clk); #2;
         k++;
      end
      checkOutput({name, "_doneCycle"}, 64'(doneAt), 64'(expLat));
      checkOutput({name, "_busyCycles"}, 64'(busyCnt), 64'(expLat));
      checkOutput({name, "_visibleCycle"}, 64'(k), 64'(expLat + 1));
      if (rd) checkOutput({name, "_stallCycles"}, 64'(stallCnt), 64'(expLat));
      checkOutput({name, "_hi"}, 64'(hi), 64'(expHi));
      checkOutput({name, "_lo"}, 64'(lo), 64'(expLo));
      rdHilo = 1'b0;
   endtask

   function automatic logic [31:0] pickOperand();
      case ($urandom_range(0, 5))
         0:       return 32'h0;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'($urandom_range(0, 20));
         default: return 32'($urandom());
      endcase
   endfunction

   initial begin
      int waitCnt;
      reset = 1'b1; start = 1'b0; opSel = 2'b00; srcA = '0; srcB = '0;
      mthi = 1'b0; mtlo = 1'b0; wdata = '0; rdHilo = 1'b0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;

      @(negedge clk);
      checkOutput("reset_hi", 64'(hi), 64'h0);
      checkOutput("reset_lo", 64'(lo), 64'h0);
      checkOutput("reset_busy", 64'(busy), 64'h0);
      checkOutput("reset_done", 64'(done), 64'h0);
      checkOutput("reset_stall", 64'(stall), 64'h0);

      applyStimulus("mult_m3x7", 2'b00, 32'hFFFF_FFFD, 32'd7, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
      applyStimulus("divu_100d7", 2'b11, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14);
      applyStimulus("div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
      applyStimulus("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h8000_0000);
      applyStimulus("divu_5d0", 2'b11, 32'd5, 32'd0, 1'b1, 32'd5, 32'hFFFF_FFFF);
      applyStimulus("multu_big", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);

      // Side write while idle, then an operation aborted by reset mid-loop.
      @(posedge clk); #2;
      mthi = 1'b1; wdata = 32'h1234;
      @(posedge clk); #2;
      mthi = 1'b0;
      @(negedge clk);
      checkOutput("mthi_hi", 64'(hi), 64'h1234);
      @(posedge clk); #2;
      start = 1'b1; opSel = FAST ? 2'b11 : 2'b01; srcA = 32'd1000; srcB = 32'd3;
      @(posedge clk); #2;
      start = 1'b0;
      doneSeen = 1'b0;
      repeat (9) @(posedge clk);
      #2 reset = 1'b1;
      @(posedge clk); #2;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("abort_hi", 64'(hi), 64'h0);
      checkOutput("abort_lo", 64'(lo), 64'h0);
      checkOutput("abort_busy", 64'(busy), 64'h0);
      checkOutput("abort_noDone", 64'(doneSeen), 64'h0);

      // Randomized traffic; the per-cycle compare checks it against the model.
      for (int i = 0; i < 3000; i++) begin
         @(posedge clk); #2;
         start  = ($urandom_range(0, 7) == 0);
         opSel  = 2'($urandom_range(0, 3));
         srcA   = pickOperand();
         srcB   = pickOperand();
         mthi   = ($urandom_range(0, 9) == 0);
         mtlo   = ($urandom_range(0, 9) == 0);
         wdata  = $urandom();
         rdHilo = ($urandom_range(0, 2) == 0);
      end

      @(posedge clk); #2;
      start = 1'b0; mthi = 1'b0; mtlo = 1'b0; rdHilo = 1'b0;
      waitCnt = 0;
      while (busy === 1'b1 && waitCnt < 60) begin
         @(posedge clk); #2;
         waitCnt++;
      end
      @(negedge clk);
      checkOutput("final_idle", 64'(busy), 64'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer that owns the HI/LO register pair of the pipelined core. It accepts MULT/MULTU/DIV/DIVU from the E stage and runs a radix-2 shift-add or restoring-divide loop. It raises STALL toward the hazard logic whenever a later instruction needs HI/LO, or needs the unit itself, before the operation has finished. MTHI/MTLO are serviced directly, and HI/LO are presented to the E-stage result mux.

## Interface
- WIDTH, 32, operand width; product and remainder/quotient pair is 2*WIDTH
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  valid mul/div operation in E stage this cycle
- OP  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- SRC_A  in  WIDTH  rs operand (multiplicand / dividend)
- SRC_B  in  WIDTH  rt operand (multiplier / divisor)
- MTHI  in  1  write WDATA to HI
- MTLO  in  1  write WDATA to LO
- WDATA  in  WIDTH  MTHI/MTLO data
- RD_HILO  in  1  MFHI or MFLO present in E stage
- BUSY  out  1  operation in progress
- STALL  out  1  freeze D/E; asserted while BUSY & (START | MTHI | MTLO | RD_HILO)
- DONE  out  1  one-cycle pulse on the cycle HI/LO update
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation
- FSM states: IDLE, RUN, FIX.
- IDLE → RUN on START. On entry, latch magnitudes |A| and |B|: the signed ops take the magnitude of each negative operand, the unsigned ops take operands as-is. Also latch neg_q = sA^sB and neg_r = sA (both 0 for unsigned) and load count = WIDTH-1.
- IDLE → FIX directly on DIV/DIVU with SRC_B == 0. This is the divide-by-zero path.
- RUN: one iteration per cycle. RUN → FIX when count == 0, otherwise count decrements.
  - Multiply: 2*WIDTH accumulator, shift-add on LSB of the multiplier.
  - Divide: restoring; shift the remainder left, subtract the divisor, set the quotient bit if the difference is non-negative.
- FIX: apply sign correction, write HI/LO, pulse DONE, return to IDLE.
  - Multiply: {HI,LO} = neg_q ? −product : product.
  - Divide: LO = neg_q ? −quot : quot; HI = neg_r ? −rem : rem.
- Divide by zero: LO = all ones, HI = SRC_A as latched.
- Signed overflow (DIV of −2^(WIDTH−1) by −1): LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic and needs no special case.
- MTHI/MTLO: accepted only in IDLE without START; the register updates on the next edge. START with MTHI/MTLO in the same cycle is illegal; START wins.
- START, MTHI, MTLO and RD_HILO while BUSY are not accepted. STALL holds them in E until BUSY drops.
- BUSY = (state != IDLE).

## Timing
- Reset: state IDLE, HI = 0, LO = 0, BUSY = 0, DONE = 0, STALL = 0. Reset mid-operation aborts, with no partial HI/LO write.
- START sampled at edge t:
  - RUN occupies cycles t+1 .. t+WIDTH.
  - FIX occupies cycle t+WIDTH+1, with DONE high in that cycle.
  - New HI/LO are visible from cycle t+WIDTH+2. Total latency is WIDTH+2 cycles.
- Divide by zero: FIX in cycle t+1; HI/LO visible at t+2.
- MFHI/MFLO in E during FIX: STALL is asserted (BUSY = 1). Next cycle BUSY = 0, STALL drops, and the new HI/LO are read.
- STALL is combinational from the registered BUSY and the E-stage inputs. There is no combinational path from SRC_A/SRC_B to any output.
- A START that arrives in the same cycle the FSM returns to IDLE is accepted normally, giving back-to-back ops with one idle-free gap.

## Configuration
- MULDIV_FAST_MUL_EN defined:
  - MULT/MULTU compute the full product with a single-cycle multiplier on the latched magnitudes.
  - The path is IDLE → FIX, so HI/LO are visible at t+2.
  - Divide still iterates.
- Undefined: multiply uses the WIDTH-cycle shift-add loop, and no multiplier is inferred.

## Test plan
- MULT: SRC_A = −3, SRC_B = 7, then MFLO next cycle.
  - STALL high until BUSY drops.
  - Result: HI = 0xFFFFFFFF, LO = 0xFFFFFFEB; DONE at t+33 (fast: t+1).
- DIVU: 100 / 7.
  - Result: LO = 14, HI = 2, visible at t+34.
  - BUSY high for exactly 33 cycles.
- DIV: −7 / 2.
  - Result: LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV: 0x80000000 / −1.
  - Result: LO = 0x80000000, HI = 0.
- DIVU: 5 / 0.
  - FIX at t+1.
  - Result: LO = 0xFFFFFFFF, HI = 5.
- Abort and side writes: MTHI 0x1234 while idle gives HI = 0x1234 next cycle. Then START MULTU, and assert RESET in RUN cycle 10.
  - Result: HI = LO = 0, BUSY = 0, and DONE is never pulsed.
